// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned multiplier: carry-save accumulation of BITS_PER_CYCLE partial
// products per cycle, followed by one carry-propagate add to resolve the product.
module csa_seq_multiplier #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  if ((WIDTH < 4) ||
      ((BITS_PER_CYCLE != 1) && (BITS_PER_CYCLE != 2) && (BITS_PER_CYCLE != 4)) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("csa_seq_multiplier: unsupported WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    carry;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    sum_nxt;
  logic [PW-1:0]    carry_nxt;

  // Rows of 3:2 compressors folding one shifted partial product each into sum/carry.
  // Bits shifted past PW are dropped; the pair stays congruent to the product mod 2^PW.
  always_comb begin
    logic [PW-1:0] s_v;
    logic [PW-1:0] c_v;
    logic [PW-1:0] pp;
    logic [PW-1:0] t_v;
    s_v = sum;
    c_v = carry;
    pp  = '0;
    t_v = '0;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      pp  = mplier[j] ? (mcand << j) : '0;
      t_v = s_v ^ c_v ^ pp;
      c_v = ((s_v & c_v) | (s_v & pp) | (c_v & pp)) << 1;
      s_v = t_v;
    end
    sum_nxt   = s_v;
    carry_nxt = c_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      sum     <= '0;
      carry   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= PW'(a);
            mplier <= b;
            sum    <= '0;
            carry  <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          sum    <= sum_nxt;
          carry  <= carry_nxt;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          product <= sum + carry;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Directed and random checks of csa_seq_multiplier in the 32/2 and 8/1 configurations.
module tb_csa_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        busy32;
  logic        done32;
  logic [63:0] product32;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(product32)
  );

  csa_seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done32 : done8;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy32 : busy8;
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    return (sel == 0) ? product32 : 64'(product8);
  endfunction

  task automatic drive(input int sel, input logic s, input logic [31:0] x, input logic [31:0] y);
    if (sel == 0) begin
      start32 = s; a32 = x; b32 = y;
    end else begin
      start8 = s; a8 = x[7:0]; b8 = y[7:0];
    end
  endtask

  // Waits for done; lat0 is the number of edges already elapsed since the start edge.
  task automatic wait_done(input int sel, input int lat0, input logic [63:0] exp, input int exp_lat,
                           input bit scramble, input bit hold_chk, input logic [63:0] hold,
                           input string name);
    int lat;
    lat = lat0;
    while (!get_done(sel) && lat < 64) begin
      chk({name, "_busy"}, 64'(get_busy(sel)), 64'd1);
      if (hold_chk) chk({name, "_hold"}, get_prod(sel), hold);
      if (scramble) drive(sel, 1'b0, $urandom, $urandom);
      tick();
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_product"}, get_prod(sel), exp);
    chk({name, "_busy_done"}, 64'(get_busy(sel)), 64'd0);
  endtask

  task automatic run_op(input int sel, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int exp_lat, input bit scramble,
                        input string name);
    drive(sel, 1'b1, x, y);
    tick();
    drive(sel, 1'b0, x, y);
    wait_done(sel, 0, exp, exp_lat, scramble, 1'b0, '0, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 17});
    vecs.push_back('{0, 32'd12345,    32'd6789,     64'd83810205,         17});
    vecs.push_back('{0, 32'h80000000, 32'd2,        64'h0000000100000000, 17});
    vecs.push_back('{0, 32'd7,        32'd9,        64'd63,               17});
    vecs.push_back('{0, 32'd0,        32'd0,        64'd0,                17});
    vecs.push_back('{0, 32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF, 17});
    vecs.push_back('{0, 32'h00010000, 32'h00010000, 64'h0000000100000000, 17});
    vecs.push_back('{1, 32'hFF,       32'hFF,       64'hFE01,             9});
    vecs.push_back('{1, 32'h80,       32'h02,       64'h0100,             9});
    vecs.push_back('{1, 32'h10,       32'h10,       64'h0100,             9});
    vecs.push_back('{1, 32'h00,       32'hAB,       64'h0000,             9});
    vecs.push_back('{1, 32'h01,       32'hFF,       64'h00FF,             9});

    // Reset applied before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_prod32", product32, 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_prod8", 64'(product8), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
    end

    // Operands change every cycle after the start edge
    run_op(0, 32'd0, 32'hDEADBEEF, 64'd0, 17, 1'b1, "zero_scramble");

    // Back-to-back: second start in the done cycle, first product must hold meanwhile
    run_op(0, 32'd12345, 32'd6789, 64'd83810205, 17, 1'b0, "b2b_first");
    drive(0, 1'b1, 32'h80000000, 32'd2);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0);
    wait_done(0, 1, 64'h0000000100000000, 18, 1'b0, 1'b1, 64'd83810205, "b2b_second");

    // Start pulsed while busy must be ignored
    drive(0, 1'b1, 32'd7, 32'd9);
    tick();
    drive(0, 1'b0, 32'd7, 32'd9);
    for (int i = 0; i < 4; i++) tick();
    drive(0, 1'b1, 32'd100, 32'd100);
    tick();
    drive(0, 1'b0, 32'd100, 32'd100);
    wait_done(0, 5, 64'd63, 17, 1'b0, 1'b0, '0, "ignored_start");
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("ignored_no_second_done", 64'(done32), 64'd0);
    end

    // Abort mid-operation with an asynchronous reset
    drive(0, 1'b1, 32'd5, 32'd5);
    tick();
    drive(0, 1'b0, 32'd5, 32'd5);
    for (int i = 0; i < 7; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy32), 64'd0);
    chk("abort_done", 64'(done32), 64'd0);
    chk("abort_prod", product32, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("abort_no_done", 64'(done32), 64'd0);
    end
    chk("abort_prod_after", product32, 64'd0);

    // Start held through reset: only the first edge after release accepts it
    rst = 1'b1;
    drive(0, 1'b1, 32'd3, 32'd5);
    tick();
    chk("start_in_rst_busy", 64'(busy32), 64'd0);
    rst = 1'b0;
    tick();
    drive(0, 1'b0, 32'd0, 32'd0);
    wait_done(0, 0, 64'd15, 17, 1'b0, 1'b0, '0, "start_after_rst");

    // Random operands against a plain multiply
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom;
      y = $urandom;
      run_op(0, x, y, 64'(x) * 64'(y), 17, 1'b0, "rand32");
    end
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = 32'($urandom_range(0, 255));
      y = 32'($urandom_range(0, 255));
      run_op(1, x, y, 64'(x) * 64'(y), 9, 1'b0, "rand8");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_seq_multiplier.md
CSA_SEQ_MULTIPLIER -- requirements
Module: csa_seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2: multiplier bits consumed per accumulate cycle.
REQ-003 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; product valid.
REQ-010 SHALL have port product  output  2*WIDTH  registered unsigned a*b.

Function
REQ-011 SHALL reject at elaboration any configuration where WIDTH<4, BITS_PER_CYCLE is not 1, 2 or 4, or WIDTH mod BITS_PER_CYCLE != 0.
REQ-012 SHALL implement FSM states IDLE, ACCUM and RESOLVE; N = WIDTH/BITS_PER_CYCLE.
REQ-013 IDLE: start=1 at a clock edge captures a and b into internal registers, clears the carry-save sum/carry vectors, clears the cycle counter, and moves to ACCUM; start=0 stays in IDLE.
REQ-014 ACCUM: each edge adds BITS_PER_CYCLE shifted partial products (a AND b[i]) into the sum/carry pair through rows of full-adder cells (3:2 compression); no carry propagation in this state.
REQ-015 ACCUM SHALL last exactly N edges, counter 0..N-1, then move to RESOLVE.
REQ-016 RESOLVE: one edge loads product with sum+carry, a single 2*WIDTH-bit carry-propagate add, truncated to 2*WIDTH bits (exact, no overflow possible), sets done=1 and returns to IDLE.
REQ-017 done SHALL be high for exactly one cycle, the cycle immediately after the RESOLVE edge, and SHALL be 0 otherwise.
REQ-018 Latency: with start sampled at edge E, product is valid and done=1 after edge E+N+1; for WIDTH=32, BITS_PER_CYCLE=2 that is edge E+17.
REQ-019 busy SHALL be 1 in ACCUM and RESOLVE and 0 in IDLE, including the done cycle.
REQ-020 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the running operation.
REQ-021 start asserted in the done cycle SHALL be accepted; back-to-back throughput is one result per N+2 cycles.
REQ-022 product SHALL hold its last value until the next RESOLVE edge; a new start SHALL NOT clear it.
REQ-023 a and b SHALL be don't-care after the start edge; changes during ACCUM SHALL NOT affect the result.
REQ-024 Operands of zero SHALL take the full N+1 latency, with no early termination.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, product=0, counter=0, sum/carry=0.
REQ-026 rst asserted mid-operation SHALL abort it; after release no done pulse for the aborted operation SHALL appear.
REQ-027 start SHALL be ignored while rst=1; the first accepted start is at the first edge with rst=0.

Verification
REQ-028 Reset: assert rst mid-cycle -> busy=0, done=0, product=0 before the next clk edge.
REQ-029 WIDTH=32, K=2: a=32'hFFFFFFFF, b=32'hFFFFFFFF, start one cycle -> done at edge +17, product=64'hFFFFFFFE00000001, busy=1 for edges +1..+17.
REQ-030 Back-to-back: 32'd12345 * 32'd6789, then start in the done cycle with 32'h80000000 * 32'd2 -> first product 64'd83810205; second done 18 edges later with 64'h0000000100000000; product holds 83810205 in between.
REQ-031 Ignored start and abort: pulse start at edge +5 of a 7*9 operation -> single done with 63. Separately, assert rst at edge +8 of another operation -> no done, product=0.
REQ-032 Zero and operand change: 0*32'hDEADBEEF, with a and b randomised after the start edge -> product=0 at edge +17.
REQ-033 Alternate config WIDTH=8, BITS_PER_CYCLE=1: 8'hFF*8'hFF -> product=16'hFE01, done at edge +9. Also 1000 random operand pairs in each configuration must match a reference model.
